// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if -- bundle between the execution sources and the common data
// bus transmit arbiter.
//
// Handshake: source i drives src_valid[i] with its result fields and keeps
// them stable until a posedge at which src_valid[i] && src_accept[i]; that
// edge is the transfer. src_accept[i] does not depend on src_valid[i], so a
// source may look at it before deciding to present.
//
// Signals (all per source unless noted):
//   src_valid, src_dest, src_value, src_upc, src_upc_value, src_ready  (source -> arbiter)
//   src_accept                                                          (arbiter -> source)
//   data_bus  registered broadcast {dest,value,update_pc_value,update_pc,ready} (shared)
//   busy      any holding slot occupied (shared)
// Modports: master = sources/consumers, slave = arbiter.

`ifndef REORDER_ID_INVALID
`define REORDER_ID_INVALID 4'hF
`endif

interface cdb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int ROB_W   = 4,
  parameter int WORD_W  = 16
);
  typedef struct packed {
    logic [ROB_W-1:0]  dest;
    logic [WORD_W-1:0] value;
    logic [WORD_W-1:0] update_pc_value;
    logic              update_pc;
    logic              ready;
  } cdb_t;

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][ROB_W-1:0]  src_dest;
  logic [NUM_SRC-1:0][WORD_W-1:0] src_value;
  logic [NUM_SRC-1:0]             src_upc;
  logic [NUM_SRC-1:0][WORD_W-1:0] src_upc_value;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0]             src_accept;
  cdb_t                           data_bus;
  logic                           busy;

  modport master (
    output src_valid, src_dest, src_value, src_upc, src_upc_value, src_ready,
    input  src_accept, data_bus, busy
  );

  modport slave (
    input  src_valid, src_dest, src_value, src_upc, src_upc_value, src_ready,
    output src_accept, data_bus, busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- transmit side of the common data bus.
// Each source owns a one-entry holding slot. Every cycle one occupied slot
// is granted round-robin (scan starts at rr_ptr) and its contents are
// registered onto data_bus for exactly one cycle.
//
// Ports:
//   clk    clock, all state updates on posedge
//   rst    asynchronous active-high reset
//   flush  synchronous ROB flush, discards every pending result
//   bus    cdb_arbiter_if.slave: source handshakes, data_bus, busy

`ifndef REORDER_ID_INVALID
`define REORDER_ID_INVALID 4'hF
`endif

module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ROB_W   = 4,
  parameter int WORD_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_SRC);
  localparam logic [ROB_W-1:0] ROB_ID_INVALID = ROB_W'(`REORDER_ID_INVALID);

  // holding slots
  logic [NUM_SRC-1:0]             hv_q, hv_d;
  logic [NUM_SRC-1:0][ROB_W-1:0]  hdest_q, hdest_d;
  logic [NUM_SRC-1:0][WORD_W-1:0] hval_q, hval_d;
  logic [NUM_SRC-1:0][WORD_W-1:0] hupcv_q, hupcv_d;
  logic [NUM_SRC-1:0]             hupc_q, hupc_d;
  logic [NUM_SRC-1:0]             hrdy_q, hrdy_d;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  // registered bus
  logic [ROB_W-1:0]  cdb_dest_q, cdb_dest_d;
  logic [WORD_W-1:0] cdb_value_q, cdb_value_d;
  logic [WORD_W-1:0] cdb_upcv_q, cdb_upcv_d;
  logic              cdb_upc_q, cdb_upc_d;
  logic              cdb_ready_q, cdb_ready_d;

  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   gidx;
  logic               found;
  logic [PTR_W-1:0]   idx;
  logic [NUM_SRC-1:0] accept;

  // Round-robin pick: first occupied slot at or after rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && hv_q[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // A slot can take a new result when empty or when it is draining this
  // cycle, which gives back-to-back throughput per source.
  assign accept = {NUM_SRC{!rst && !flush}} & (~hv_q | grant);

  always_comb begin
    hv_d        = hv_q;
    hdest_d     = hdest_q;
    hval_d      = hval_q;
    hupcv_d     = hupcv_q;
    hupc_d      = hupc_q;
    hrdy_d      = hrdy_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_dest_d  = ROB_ID_INVALID;
    cdb_value_d = '0;
    cdb_upcv_d  = '0;
    cdb_upc_d   = 1'b0;
    cdb_ready_d = 1'b0;
    if (flush) begin
      // grant computed this cycle is dropped; bus goes idle
      hv_d     = '0;
      rr_ptr_d = '0;
    end else begin
      hv_d = hv_q & ~grant;
      for (int i = 0; i < NUM_SRC; i++) begin
        // an invalid ROB id is taken off the source but never stored
        if (bus.src_valid[i] && accept[i] && (bus.src_dest[i] != ROB_ID_INVALID)) begin
          hv_d[i]    = 1'b1;
          hdest_d[i] = bus.src_dest[i];
          hval_d[i]  = bus.src_value[i];
          hupcv_d[i] = bus.src_upc_value[i];
          hupc_d[i]  = bus.src_upc[i];
          hrdy_d[i]  = bus.src_ready[i];
        end
      end
      if (found) begin
        cdb_dest_d  = hdest_q[gidx];
        cdb_value_d = hval_q[gidx];
        cdb_upcv_d  = hupcv_q[gidx];
        cdb_upc_d   = hupc_q[gidx];
        cdb_ready_d = hrdy_q[gidx];
        rr_ptr_d    = (gidx == PTR_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv_q        <= '0;
      hdest_q     <= '0;
      hval_q      <= '0;
      hupcv_q     <= '0;
      hupc_q      <= '0;
      hrdy_q      <= '0;
      rr_ptr_q    <= '0;
      cdb_dest_q  <= ROB_ID_INVALID;
      cdb_value_q <= '0;
      cdb_upcv_q  <= '0;
      cdb_upc_q   <= 1'b0;
      cdb_ready_q <= 1'b0;
    end else begin
      hv_q        <= hv_d;
      hdest_q     <= hdest_d;
      hval_q      <= hval_d;
      hupcv_q     <= hupcv_d;
      hupc_q      <= hupc_d;
      hrdy_q      <= hrdy_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_value_q <= cdb_value_d;
      cdb_upcv_q  <= cdb_upcv_d;
      cdb_upc_q   <= cdb_upc_d;
      cdb_ready_q <= cdb_ready_d;
    end
  end

  assign bus.src_accept = accept;
  assign bus.data_bus   = {cdb_dest_q, cdb_value_q, cdb_upcv_q, cdb_upc_q, cdb_ready_q};
  assign bus.busy       = |hv_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Inputs change 2 time units after a posedge;
// outputs are sampled in the same window, away from the active edge.

`ifndef REORDER_ID_INVALID
`define REORDER_ID_INVALID 4'hF
`endif

module tb_cdb_arbiter;
  localparam int N = 4;
  localparam logic [3:0] INV = `REORDER_ID_INVALID;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(N), .ROB_W(4), .WORD_W(16)) bus_if ();

  cdb_arbiter #(.NUM_SRC(N), .ROB_W(4), .WORD_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_if)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_src();
    bus_if.src_valid     = '0;
    bus_if.src_dest      = '0;
    bus_if.src_value     = '0;
    bus_if.src_upc       = '0;
    bus_if.src_upc_value = '0;
    bus_if.src_ready     = '0;
  endtask

  task automatic drive(input int s, input logic [3:0] d, input logic [15:0] v,
                       input logic upc, input logic [15:0] upcv, input logic rdy);
    bus_if.src_valid[s]     = 1'b1;
    bus_if.src_dest[s]      = d;
    bus_if.src_value[s]     = v;
    bus_if.src_upc[s]       = upc;
    bus_if.src_upc_value[s] = upcv;
    bus_if.src_ready[s]     = rdy;
  endtask

  // leaves the bench in cycle 0 of a fresh run with rr_ptr at 0
  task automatic do_reset();
    @(posedge clk);
    #2;
    clear_src();
    flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_dest", bus_if.data_bus.dest, INV);
    chk("rst_value", bus_if.data_bus.value, 16'h0);
    chk("rst_upc", bus_if.data_bus.update_pc, 1'b0);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_accept", bus_if.src_accept, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] acc_e;
    logic [3:0] dest_e;
    logic [3:0] one;
    int cnt[2];
    int wt[2];
    logic xfer[2];
    int first_c;
    int last_c;

    clear_src();
    one = 4'b0001;

    // 1: single result, minimum latency, one cycle on bus
    do_reset();
    drive(2, 4'd3, 16'h1234, 1'b0, 16'h0, 1'b1);
    #1;
    chk("t1_acc0", bus_if.src_accept[2], 1'b1);
    chk("t1_bus0", bus_if.data_bus.dest, INV);
    tick();
    clear_src();
    chk("t1_bus1", bus_if.data_bus.dest, INV);
    chk("t1_busy1", bus_if.busy, 1'b1);
    tick();
    chk("t1_dest2", bus_if.data_bus.dest, 4'd3);
    chk("t1_value2", bus_if.data_bus.value, 16'h1234);
    chk("t1_ready2", bus_if.data_bus.ready, 1'b1);
    chk("t1_busy2", bus_if.busy, 1'b0);
    tick();
    chk("t1_dest3", bus_if.data_bus.dest, INV);
    chk("t1_ready3", bus_if.data_bus.ready, 1'b0);

    // 2: all four sources at once, drained 0..3
    do_reset();
    for (int s = 0; s < N; s++) drive(s, 4'(s), 16'h0100 + 16'(s), 1'b0, 16'h0, 1'b0);
    #1;
    chk("t2_acc0", bus_if.src_accept, 4'b1111);
    tick();
    clear_src();
    for (int c = 1; c <= 6; c++) begin
      acc_e  = (c >= 4) ? 4'b1111 : (one << c) - 4'b0001;
      dest_e = (c >= 2 && c <= 5) ? 4'(c - 2) : INV;
      chk($sformatf("t2_acc_c%0d", c), bus_if.src_accept, acc_e);
      chk($sformatf("t2_dest_c%0d", c), bus_if.data_bus.dest, dest_e);
      chk($sformatf("t2_busy_c%0d", c), bus_if.busy, (c <= 4) ? 1'b1 : 1'b0);
      if (c >= 2 && c <= 5)
        chk($sformatf("t2_value_c%0d", c), bus_if.data_bus.value, 16'h0100 + 16'(c - 2));
      if (c < 6) tick();
    end

    // 3: one source streaming every cycle, no bubbles
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) drive(0, 4'(c), 16'hA000 + 16'(c), 1'b0, 16'h0, 1'b1);
      else clear_src();
      #1;
      if (c < 8) chk($sformatf("t3_acc_c%0d", c), bus_if.src_accept[0], 1'b1);
      dest_e = (c >= 2 && c <= 9) ? 4'(c - 2) : INV;
      chk($sformatf("t3_dest_c%0d", c), bus_if.data_bus.dest, dest_e);
      if (c >= 2 && c <= 9)
        chk($sformatf("t3_value_c%0d", c), bus_if.data_bus.value, 16'hA000 + 16'(c - 2));
      tick();
    end
    clear_src();

    // 4: two sources streaming, bus alternates, no source starves
    do_reset();
    exp_q.delete();
    for (int d = 0; d < 12; d++) exp_q.push_back(4'(d));
    cnt[0] = 0; cnt[1] = 0; wt[0] = 0; wt[1] = 0;
    first_c = -1; last_c = -1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus_if.data_bus.dest !== INV) begin
        chk($sformatf("t4_order_c%0d", c), bus_if.data_bus.dest, exp_q.pop_front());
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      for (int s = 0; s < 2; s++) begin
        if (cnt[s] < 6) drive(s, 4'(2 * cnt[s] + s), 16'hC000 + 16'(2 * cnt[s] + s), 1'b0, 16'h0, 1'b1);
        else bus_if.src_valid[s] = 1'b0;
      end
      #1;
      for (int s = 0; s < 2; s++) begin
        xfer[s] = bus_if.src_valid[s] && bus_if.src_accept[s];
        if (bus_if.src_valid[s] && !bus_if.src_accept[s]) wt[s]++;
        else if (xfer[s]) begin
          chk($sformatf("t4_wait_s%0d", s), (wt[s] <= 1), 1'b1);
          wt[s] = 0;
        end
      end
      tick();
      for (int s = 0; s < 2; s++) if (xfer[s]) cnt[s]++;
    end
    chk("t4_drain", exp_q.size(), 0);
    chk("t4_span", last_c - first_c, 11);
    clear_src();

    // 5: flush with three slots full
    do_reset();
    drive(0, 4'd4, 16'h4444, 1'b0, 16'h0, 1'b1);
    drive(1, 4'd5, 16'h5555, 1'b0, 16'h0, 1'b1);
    drive(2, 4'd6, 16'h6666, 1'b0, 16'h0, 1'b1);
    tick();
    clear_src();
    flush = 1'b1;
    #1;
    chk("t5_acc_flush", bus_if.src_accept, 4'b0000);
    chk("t5_busy_flush", bus_if.busy, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk("t5_dest_after", bus_if.data_bus.dest, INV);
    chk("t5_busy_after", bus_if.busy, 1'b0);
    chk("t5_acc_after", bus_if.src_accept, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t5_idle_c%0d", c), bus_if.data_bus.dest, INV);
    end

    // 7: invalid ROB id is accepted and dropped
    do_reset();
    drive(1, INV, 16'hBEEF, 1'b1, 16'h1111, 1'b1);
    #1;
    chk("t7_acc", bus_if.src_accept[1], 1'b1);
    tick();
    clear_src();
    chk("t7_busy", bus_if.busy, 1'b0);
    tick();
    chk("t7_dest", bus_if.data_bus.dest, INV);
    chk("t7_value", bus_if.data_bus.value, 16'h0);
    chk("t7_upc", bus_if.data_bus.update_pc, 1'b0);

    // 6: asynchronous reset mid-cycle clears the bus without an edge
    do_reset();
    drive(1, 4'd5, 16'h5A5A, 1'b1, 16'h3000, 1'b1);
    tick();
    clear_src();
    drive(3, 4'd7, 16'h7777, 1'b0, 16'h0, 1'b1);
    tick();
    clear_src();
    chk("t6_dest", bus_if.data_bus.dest, 4'd5);
    chk("t6_upc", bus_if.data_bus.update_pc, 1'b1);
    chk("t6_upcv", bus_if.data_bus.update_pc_value, 16'h3000);
    chk("t6_busy", bus_if.busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_dest", bus_if.data_bus.dest, INV);
    chk("t6_rst_upc", bus_if.data_bus.update_pc, 1'b0);
    chk("t6_rst_upcv", bus_if.data_bus.update_pc_value, 16'h0);
    chk("t6_rst_busy", bus_if.busy, 1'b0);
    chk("t6_rst_acc", bus_if.src_accept, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t6_lost_c%0d", c), bus_if.data_bus.dest, INV);
      chk($sformatf("t6_busy_c%0d", c), bus_if.busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
